// File: rtl/tube_sequencer_pkg.sv
// Shared types and constants for the tube sequencer and the tube stages it drives.
package tube_sequencer_pkg;

  // Pre-trigger history depth of the tube stages' shift registers.
  localparam int PRIOR_CLK_CYC = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_ARM      = 3'd2,
    ST_FREEZE   = 3'd3,
    ST_VALIDATE = 3'd4,
    ST_READOUT  = 3'd5
  } state_t;

  typedef struct packed {
    logic tube_clr;
    logic gate_enable;
    logic shift_freeze;
    logic validate;
    logic readout_req;
    logic busy;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_CLEAR:    begin c.tube_clr = 1'b1; c.busy = 1'b1; end
      ST_ARM,
      ST_FREEZE:   begin c.gate_enable = 1'b1; c.shift_freeze = 1'b1; c.busy = 1'b1; end
      ST_VALIDATE: begin
        c.gate_enable  = 1'b1;
        c.shift_freeze = 1'b1;
        c.validate     = 1'b1;
        c.busy         = 1'b1;
      end
      ST_READOUT:  begin c.shift_freeze = 1'b1; c.readout_req = 1'b1; c.busy = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/trig_sync.sv
// Two-flop synchroniser and registered rising-edge detector for the external trigger.
module trig_sync (
  input  logic clk,
  input  logic clr,
  input  logic trigger,
  output logic rise
);

  logic       meta;
  logic       sync;
  logic       hist;
  logic [1:0] warm;

  // hist is forced high until the synchroniser carries real samples, so a trigger
  // already high when reset releases is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b1;
      warm <= 2'b00;
      rise <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value of its
      // neighbour, which is what makes meta -> sync a real two-stage synchroniser.
      meta <= trigger;
      sync <= meta;
      warm <= {warm[0], 1'b1};
      hist <= sync | ~warm[1];
      rise <= sync & ~hist;
    end
  end

endmodule

// File: rtl/tube_sequencer.sv
// Tube readout sequencer: trigger -> clear -> gate window -> freeze -> validate -> readout.
// Optional build macro TUBE_SEQ_TRIGCNT_EN adds accepted/dropped trigger counters.
module tube_sequencer
  import tube_sequencer_pkg::*;
#(
  parameter int GATE_CYCLES = 200,
  parameter int CLR_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        trigger,
  input  logic        readoutAck,
  output logic        tubeClr,
  output logic        gateEnable,
  output logic        shiftFreeze,
  output logic        validateOut,
  output logic        readoutReq,
  output logic        busy,
  output logic [7:0]  windowCnt
`ifdef TUBE_SEQ_TRIGCNT_EN
  ,
  output logic [15:0] trigCount,
  output logic [15:0] dropCount
`endif
);

  localparam logic [7:0] GATE_LAST = 8'(GATE_CYCLES - 1);
  localparam logic [3:0] CLR_LAST  = 4'(CLR_CYCLES - 1);

  logic       rise;
  state_t     state, state_d;
  logic [7:0] win, win_d;
  logic [3:0] clr_cnt, clr_cnt_d;
  ctrl_t      ctrl, ctrl_d;

  trig_sync u_trig_sync (
    .clk     (clk),
    .clr     (clr),
    .trigger (trigger),
    .rise    (rise)
  );

  always_comb begin
    // NOTE: every variable gets its default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d   = state;
    win_d     = win;
    clr_cnt_d = clr_cnt;
    case (state)
      ST_IDLE: begin
        win_d     = '0;
        clr_cnt_d = '0;
        if (rise) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = ST_ARM;
        end else begin
          clr_cnt_d = clr_cnt + 4'd1;
        end
      end
      ST_ARM: begin
        if (win == GATE_LAST) state_d = ST_FREEZE;
        else                  win_d   = win + 8'd1;
      end
      ST_FREEZE:   state_d = ST_VALIDATE;
      ST_VALIDATE: state_d = ST_READOUT;
      ST_READOUT: begin
        if (readoutAck) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        win_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state and registered, so they line up with
    // the state register and never see an input combinationally.
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= ST_IDLE;
      win     <= '0;
      clr_cnt <= '0;
      ctrl    <= '0;
    end else begin
      state   <= state_d;
      win     <= win_d;
      clr_cnt <= clr_cnt_d;
      ctrl    <= ctrl_d;
    end
  end

  assign tubeClr     = ctrl.tube_clr;
  assign gateEnable  = ctrl.gate_enable;
  assign shiftFreeze = ctrl.shift_freeze;
  assign validateOut = ctrl.validate;
  assign readoutReq  = ctrl.readout_req;
  assign busy        = ctrl.busy;
  assign windowCnt   = win;

`ifdef TUBE_SEQ_TRIGCNT_EN
  logic [15:0] trig_cnt;
  logic [15:0] drop_cnt;

  // An edge reaching a non-idle FSM is discarded, and counted as dropped.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      trig_cnt <= '0;
      drop_cnt <= '0;
    end else if (rise) begin
      if (state == ST_IDLE) begin
        if (trig_cnt != 16'hFFFF) trig_cnt <= trig_cnt + 16'd1;
      end else begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign trigCount = trig_cnt;
  assign dropCount = drop_cnt;
`endif

endmodule

// File: tb/tb_tube_sequencer.sv
// Self-checking bench for tube_sequencer: two instances (GATE 200/CLR 2 and GATE 1/CLR 3)
// compared every cycle against a timeline model, plus directed boundary scenarios.
module tb_tube_sequencer;

  typedef struct packed {
    logic       tube_clr;
    logic       gate;
    logic       freeze;
    logic       validate;
    logic       req;
    logic       busy;
    logic [7:0] win;
  } obs_t;

  logic clk        = 1'b0;
  logic clr        = 1'b1;
  logic trigger    = 1'b0;
  logic readoutAck = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] tube_clr, gate_en, shift_frz, valid_out, ro_req, busy;
  logic [7:0] win_cnt [2];
`ifdef TUBE_SEQ_TRIGCNT_EN
  logic [15:0] trig_cnt [2];
  logic [15:0] drop_cnt [2];
`endif

  tube_sequencer #(.GATE_CYCLES(200), .CLR_CYCLES(2)) dut_a (
    .clk(clk), .clr(clr), .trigger(trigger), .readoutAck(readoutAck),
    .tubeClr(tube_clr[0]), .gateEnable(gate_en[0]), .shiftFreeze(shift_frz[0]),
    .validateOut(valid_out[0]), .readoutReq(ro_req[0]), .busy(busy[0]),
    .windowCnt(win_cnt[0])
`ifdef TUBE_SEQ_TRIGCNT_EN
    , .trigCount(trig_cnt[0]), .dropCount(drop_cnt[0])
`endif
  );

  tube_sequencer #(.GATE_CYCLES(1), .CLR_CYCLES(3)) dut_b (
    .clk(clk), .clr(clr), .trigger(trigger), .readoutAck(readoutAck),
    .tubeClr(tube_clr[1]), .gateEnable(gate_en[1]), .shiftFreeze(shift_frz[1]),
    .validateOut(valid_out[1]), .readoutReq(ro_req[1]), .busy(busy[1]),
    .windowCnt(win_cnt[1])
`ifdef TUBE_SEQ_TRIGCNT_EN
    , .trigCount(trig_cnt[1]), .dropCount(drop_cnt[1])
`endif
  );

  function automatic int gp(input int d);
    return (d == 0) ? 200 : 1;
  endfunction

  function automatic int cp(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  // Reference model: trigger samples per edge, and for each instance the edge number
  // at which its sequence began; outputs follow from the offset into the timeline.
  int          m_n = 0;
  logic [3:0]  samp = 4'hF;
  bit          m_busy [2] = '{0, 0};
  int          m_start [2] = '{0, 0};
  logic [15:0] m_trig [2] = '{16'd0, 16'd0};
  logic [15:0] m_drop [2] = '{16'd0, 16'd0};

  always @(posedge clk or posedge clr) begin
    bit rise;
    if (clr) begin
      m_n  = 0;
      samp = 4'hF;
      for (int d = 0; d < 2; d++) begin
        m_busy[d] = 0; m_start[d] = 0; m_trig[d] = '0; m_drop[d] = '0;
      end
    end else begin
      m_n++;
      rise = samp[2] & ~samp[3];
      for (int d = 0; d < 2; d++) begin
        if (!m_busy[d]) begin
          if (rise) begin
            m_busy[d]  = 1;
            m_start[d] = m_n;
            if (m_trig[d] != 16'hFFFF) m_trig[d]++;
          end
        end else begin
          if (rise && m_drop[d] != 16'hFFFF) m_drop[d]++;
          if ((m_n - 1 - m_start[d]) >= cp(d) + gp(d) + 2 && readoutAck) m_busy[d] = 0;
        end
      end
      samp = {samp[2:0], trigger};
    end
  end

  function automatic obs_t exp_obs(input int d);
    obs_t e;
    int   off, g, c;
    e = '0;
    g = gp(d);
    c = cp(d);
    if (m_busy[d]) begin
      off        = m_n - m_start[d];
      e.busy     = 1'b1;
      e.tube_clr = off < c;
      e.gate     = (off >= c) && (off < c + g + 2);
      e.freeze   = off >= c;
      e.validate = off == c + g + 1;
      e.req      = off >= c + g + 2;
      if (off >= c) e.win = 8'(((off - c) < (g - 1)) ? (off - c) : (g - 1));
    end
    return e;
  endfunction

  function automatic obs_t get_obs(input int d);
    obs_t o;
    o.tube_clr = tube_clr[d];
    o.gate     = gate_en[d];
    o.freeze   = shift_frz[d];
    o.validate = valid_out[d];
    o.req      = ro_req[d];
    o.busy     = busy[d];
    o.win      = win_cnt[d];
    return o;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare(input int d);
    obs_t  o, e;
    string p;
    o = get_obs(d);
    e = exp_obs(d);
    p = (d == 0) ? "a" : "b";
    check({p, ".tubeClr"},     o.tube_clr, e.tube_clr);
    check({p, ".gateEnable"},  o.gate,     e.gate);
    check({p, ".shiftFreeze"}, o.freeze,   e.freeze);
    check({p, ".validateOut"}, o.validate, e.validate);
    check({p, ".readoutReq"},  o.req,      e.req);
    check({p, ".busy"},        o.busy,     e.busy);
    check({p, ".windowCnt"},   o.win,      e.win);
`ifdef TUBE_SEQ_TRIGCNT_EN
    check({p, ".trigCount"},   trig_cnt[d], m_trig[d]);
    check({p, ".dropCount"},   drop_cnt[d], m_drop[d]);
`endif
  endtask

  int   cnt_clr_a, cnt_gate_a, cnt_val_a, cnt_req_a, cnt_gate_b, cnt_req_b;
  int   busy_rise_a;
  logic prev_busy_a;
  logic [7:0] last_win_a;

  task automatic zero_counts();
    cnt_clr_a = 0; cnt_gate_a = 0; cnt_val_a = 0; cnt_req_a = 0;
    cnt_gate_b = 0; cnt_req_b = 0; busy_rise_a = 0;
    prev_busy_a = busy[0];
    last_win_a  = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    compare(0);
    compare(1);
    cnt_clr_a  += int'(tube_clr[0]);
    cnt_gate_a += int'(gate_en[0]);
    cnt_val_a  += int'(valid_out[0]);
    cnt_req_a  += int'(ro_req[0]);
    cnt_gate_b += int'(gate_en[1]);
    cnt_req_b  += int'(ro_req[1]);
    if (busy[0] && !prev_busy_a) busy_rise_a++;
    prev_busy_a = busy[0];
    if (ro_req[0]) last_win_a = win_cnt[0];
  endtask

  task automatic wait_req_a(input string tag, input int budget);
    int k = 0;
    while (!ro_req[0] && k < budget) begin tick(); k++; end
    check(tag, ro_req[0], 1'b1);
  endtask

  task automatic ack_pulse();
    readoutAck = 1'b1;
    tick();
    readoutAck = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    zero_counts();
    // Reset held, then released with no trigger activity.
    repeat (3) tick();
    check("rst.outs", {tube_clr, gate_en, shift_frz, valid_out, ro_req, busy}, 12'h0);
    clr = 1'b0;
    repeat (100) tick();
    check("idle100.busy", busy, 2'b00);
    check("idle100.win_a", win_cnt[0], 8'd0);

    // Nominal sequence, ack five cycles after readoutReq.
    zero_counts();
    trigger = 1'b1; repeat (3) tick(); trigger = 1'b0;
    wait_req_a("nom.req_seen", 500);
    repeat (4) tick();
    check("nom.busy_before_ack", busy[0], 1'b1);
    ack_pulse();
    check("nom.busy_after_ack", busy[0], 1'b0);
    check("nom.tubeClr_cycles", cnt_clr_a, 2);
    check("nom.gate_cycles", cnt_gate_a, 202);
    check("nom.validate_cycles", cnt_val_a, 1);
    check("nom.req_cycles", cnt_req_a, 5);
    check("nom.win_final", last_win_a, 8'd199);

    // Retrigger during ARM: one sequence, extra edges dropped.
    clr = 1'b1; tick(); clr = 1'b0; repeat (4) tick();
    zero_counts();
    trigger = 1'b1; repeat (2) tick(); trigger = 1'b0;
    k = 0;
    while (!gate_en[0] && k < 20) begin tick(); k++; end
    check("retrig.in_arm", gate_en[0], 1'b1);
    repeat (3) begin
      trigger = 1'b1; repeat (2) tick(); trigger = 1'b0; repeat (4) tick();
    end
    wait_req_a("retrig.req_seen", 400);
    ack_pulse();
    repeat (5) tick();
    check("retrig.sequences", busy_rise_a, 1);
`ifdef TUBE_SEQ_TRIGCNT_EN
    check("retrig.trigCount", trig_cnt[0], 16'd1);
    check("retrig.dropCount", drop_cnt[0], 16'd3);
`endif

    // Mid-run reset with trigger held high across release.
    zero_counts();
    trigger = 1'b1; repeat (2) tick(); trigger = 1'b0;
    k = 0;
    while (win_cnt[0] != 8'd50 && k < 300) begin tick(); k++; end
    check("mid.reached_50", win_cnt[0], 8'd50);
    trigger = 1'b1;
    #2 clr = 1'b1;
    #1;
    check("mid.outs_immediate", {tube_clr, gate_en, shift_frz, valid_out, ro_req, busy}, 12'h0);
    check("mid.win_immediate", {win_cnt[0], win_cnt[1]}, 16'h0);
    repeat (2) tick();
    clr = 1'b0;
    repeat (30) tick();
    check("mid.no_restart", busy, 2'b00);
    trigger = 1'b0; repeat (3) tick();
    trigger = 1'b1;
    k = 0;
    while (!busy[0] && k < 10) begin tick(); k++; end
    check("mid.fresh_edge", busy[0], 1'b1);
    trigger = 1'b0;
    wait_req_a("mid.req_seen", 400);
    ack_pulse();
    repeat (3) tick();

    // Ack already high before READOUT; GATE_CYCLES=1 instance gate length.
    readoutAck = 1'b1;
    zero_counts();
    trigger = 1'b1; repeat (2) tick(); trigger = 1'b0;
    k = 0;
    while (!busy[0] && k < 10) begin tick(); k++; end
    while (busy[0] && k < 400) begin tick(); k++; end
    check("ackhi.done", busy[0], 1'b0);
    check("ackhi.req_cycles_a", cnt_req_a, 1);
    check("ackhi.req_cycles_b", cnt_req_b, 1);
    check("ackhi.gate_cycles_b", cnt_gate_b, 3);
    readoutAck = 1'b0;
    repeat (3) tick();

    // Randomised trigger, ack and occasional reset.
    repeat (3000) begin
      if ($urandom_range(0, 11) == 0) trigger = ~trigger;
      readoutAck = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 1499) == 0);
      tick();
    end
    clr = 1'b0; trigger = 1'b0; readoutAck = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tube_sequencer.md
TUBE_SEQUENCER -- requirements
Module: tube_sequencer

Interface
REQ-001 Parameter GATE_CYCLES, default 200, SHALL set the gate-open window length in clk cycles (legal 1..248).
REQ-002 Parameter CLR_CYCLES, default 2, SHALL set the tube-clear pulse length in clk cycles (legal 1..15).
REQ-003 Port clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 Port clr  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 Port trigger  input  1  SHALL be the asynchronous external trigger, rising-edge significant.
REQ-006 Port readoutAck  input  1  SHALL be the downstream acknowledge that tube data has been taken.
REQ-007 Port tubeClr  output  1  SHALL be the clear driven to every tube stage.
REQ-008 Port gateEnable  output  1  SHALL be the tube latch gate enable / counter clock enable.
REQ-009 Port shiftFreeze  output  1  SHALL be the hold for the tubes' pre-trigger shift registers.
REQ-010 Port validateOut  output  1  SHALL be the one-cycle pulse that folds shift-register history into tube counts.
REQ-011 Port readoutReq  output  1  SHALL be the request telling downstream that tube data is valid.
REQ-012 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-013 Port windowCnt  output  8  SHALL be the current gate-window cycle count.

Function
REQ-014 trigger SHALL pass a 2-flop synchroniser plus an edge detector; a rise reaches the FSM 3 cycles after the input edge.
REQ-015 FSM states SHALL be IDLE, CLEAR, ARM, FREEZE, VALIDATE, READOUT, encoded in a 3-bit state register.
REQ-016 IDLE: all outputs low; a detected edge SHALL move to CLEAR next cycle.
REQ-017 CLEAR: tubeClr high for exactly CLR_CYCLES cycles, then ARM.
REQ-018 ARM: gateEnable and shiftFreeze high; windowCnt SHALL start at 0 and increment each cycle; leave after exactly GATE_CYCLES cycles (when windowCnt equals GATE_CYCLES-1).
REQ-019 FREEZE: gateEnable and shiftFreeze high for 1 cycle, then VALIDATE.
REQ-020 VALIDATE: gateEnable, shiftFreeze and validateOut high for exactly 1 cycle, then READOUT.
REQ-021 READOUT: shiftFreeze and readoutReq high, gateEnable low, until readoutAck is sampled high; then IDLE next cycle.
REQ-022 readoutAck SHALL be ignored outside READOUT; an ack held high on entry SHALL complete READOUT in 1 cycle.
REQ-023 Trigger edges in any state other than IDLE SHALL be discarded, not queued.
REQ-024 windowCnt SHALL hold its final value through FREEZE..READOUT and clear to 0 on return to IDLE; it never wraps.
REQ-025 Every output SHALL be driven directly from a register, with no combinational path from any input.

Reset
REQ-026 clr high SHALL asynchronously force state IDLE, all outputs 0, windowCnt 0, synchroniser flops 0, independent of clk.
REQ-027 Reset asserted mid-sequence SHALL abort it; after release a fresh trigger edge SHALL be required (a trigger already high at release SHALL NOT start a sequence).

Configuration
REQ-028 Macro TUBE_SEQ_TRIGCNT_EN defined SHALL add outputs trigCount [15:0] (accepted triggers) and dropCount [15:0] (edges discarded per REQ-023), both saturating at 16'hFFFF and cleared by clr.
REQ-029 Without TUBE_SEQ_TRIGCNT_EN those ports and counters SHALL NOT exist; all other behaviour is identical.

Structure
REQ-030 A shared package SHALL hold the state enumeration typedef and the constant PRIOR_CLK_CYC = 7 used by the tube stages.
REQ-031 The synchroniser plus edge detector SHALL be a separate sub-module named trig_sync.

Verification
REQ-032 Reset default: clr=1 then release, no trigger -> all outputs 0, busy 0 for 100 cycles.
REQ-033 Nominal: GATE_CYCLES=200, CLR_CYCLES=2, one trigger pulse, readoutAck 5 cycles after readoutReq -> tubeClr 2 cycles, gateEnable 202 cycles, validateOut 1 cycle, windowCnt final 199, busy falls 1 cycle after ack.
REQ-034 Retrigger: 3 extra trigger pulses during ARM -> single sequence only; with TUBE_SEQ_TRIGCNT_EN trigCount=1, dropCount=3.
REQ-035 Mid-run reset: clr pulsed at windowCnt=50 -> outputs 0 immediately (same cycle as clr edge); trigger held high across release -> no new sequence until it falls and rises again.
REQ-036 Ack boundary: readoutAck held high before READOUT -> readoutReq high exactly 1 cycle; GATE_CYCLES=1 -> gateEnable high 3 cycles total.
